// File: rtl/uart_rx_ctrl.sv
// Control block for the uart_rx receiver: generates the oversampling tick, applies
// configuration only between frames, and buffers received bytes with RTS flow control.
module uart_rx_ctrl #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned DIV_W      = 16,
    parameter int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_wr,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [1:0]       cfg_data_bit_num,
    input  logic             cfg_stop_bit_num,
    input  logic             cfg_parity_en,
    input  logic             cfg_parity_type,
    input  logic [LVL_W-1:0] cfg_rts_thresh,
    output logic             cfg_busy,
    input  logic             rx,
    input  logic             rx_done,
    input  logic [7:0]       rx_data,
    input  logic             parity_error,
    output logic             tick,
    output logic [1:0]       data_bit_num,
    output logic             stop_bit_num,
    output logic             parity_en,
    output logic             parity_type,
    output logic             rts_n,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [7:0]       rd_data,
    output logic             rd_perr,
    output logic [LVL_W-1:0] level,
    output logic             overrun,
    input  logic             overrun_clr
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    typedef enum logic {
        IDLE_CFG,
        PENDING
    } cfg_state_t;

    cfg_state_t       state;
    logic             frame_active;
    logic             apply;

    logic [DIV_W-1:0] sh_div;
    logic [1:0]       sh_data_bit_num;
    logic             sh_stop_bit_num;
    logic             sh_parity_en;
    logic             sh_parity_type;
    logic [LVL_W-1:0] sh_thresh;

    logic [DIV_W-1:0] act_div;
    logic [LVL_W-1:0] act_thresh;

    logic [DIV_W-1:0] tcnt;
    logic [DIV_W-1:0] tcnt_last;

    logic [8:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [8:0]       head;
    logic             fifo_full;
    logic             push;
    logic             pop;
    logic             drop;

    always_comb begin
        apply    = 1'b0;
        cfg_busy = 1'b0;
        if (state == PENDING) begin
            cfg_busy = 1'b1;
            apply    = ~frame_active;
        end
    end

    // The apply copies the shadow as it stood before this edge, so a coincident
    // cfg_wr lands in the shadow and keeps the FSM pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE_CFG;
            sh_div          <= '0;
            sh_data_bit_num <= '0;
            sh_stop_bit_num <= 1'b0;
            sh_parity_en    <= 1'b0;
            sh_parity_type  <= 1'b0;
            sh_thresh       <= '0;
            act_div         <= DIV_W'(27);
            data_bit_num    <= 2'b11;
            stop_bit_num    <= 1'b0;
            parity_en       <= 1'b0;
            parity_type     <= 1'b0;
            act_thresh      <= LVL_W'(FIFO_DEPTH - 2);
        end else begin
            if (apply) begin
                act_div      <= sh_div;
                data_bit_num <= sh_data_bit_num;
                stop_bit_num <= sh_stop_bit_num;
                parity_en    <= sh_parity_en;
                parity_type  <= sh_parity_type;
                act_thresh   <= sh_thresh;
            end
            if (cfg_wr) begin
                sh_div          <= cfg_div;
                sh_data_bit_num <= cfg_data_bit_num;
                sh_stop_bit_num <= cfg_stop_bit_num;
                sh_parity_en    <= cfg_parity_en;
                sh_parity_type  <= cfg_parity_type;
                sh_thresh       <= cfg_rts_thresh;
                state           <= PENDING;
            end else if (apply) begin
                state <= IDLE_CFG;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_active <= 1'b0;
        end else if (rx_done) begin
            frame_active <= 1'b0;
        end else if (!frame_active && !rx) begin
            frame_active <= 1'b1;
        end
    end

    // A divisor of zero maps to a terminal count of zero, i.e. a tick every cycle.
    always_comb begin
        tcnt_last = '0;
        if (act_div != '0) begin
            tcnt_last = act_div - DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || apply) begin
            tcnt <= '0;
            tick <= 1'b0;
        end else if (tcnt >= tcnt_last) begin
            tcnt <= '0;
            tick <= 1'b1;
        end else begin
            tcnt <= tcnt + DIV_W'(1);
            tick <= 1'b0;
        end
    end

    always_comb begin
        fifo_full = (level == LVL_W'(FIFO_DEPTH));
        rd_valid  = (level != '0);
        pop       = rd_valid && rd_ready;
        push      = rx_done && (!fifo_full || pop);
        drop      = rx_done && fifo_full && !pop;
        head      = mem[rd_ptr];
        rd_data   = '0;
        rd_perr   = 1'b0;
        if (rd_valid) begin
            rd_data = head[7:0];
            rd_perr = head[8];
        end
        rts_n = (level >= act_thresh);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {parity_error, rx_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            overrun <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
            if (drop) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed stimulus, FIFO contents checked through a scoreboard
// queue that a negedge monitor drains whenever the host pops.
module tb_uart_rx_ctrl;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_wr = 1'b0;
    logic [15:0] cfg_div = '0;
    logic [1:0]  cfg_data_bit_num = '0;
    logic        cfg_stop_bit_num = 1'b0;
    logic        cfg_parity_en = 1'b0;
    logic        cfg_parity_type = 1'b0;
    logic [3:0]  cfg_rts_thresh = '0;
    logic        cfg_busy;
    logic        rx = 1'b1;
    logic        rx_done = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        parity_error = 1'b0;
    logic        tick;
    logic [1:0]  data_bit_num;
    logic        stop_bit_num;
    logic        parity_en;
    logic        parity_type;
    logic        rts_n;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic [7:0]  rd_data;
    logic        rd_perr;
    logic [3:0]  level;
    logic        overrun;
    logic        overrun_clr = 1'b0;

    int checks = 0;
    int failures = 0;
    int exp_level = 0;
    logic [8:0] sb[$];

    uart_rx_ctrl #(.FIFO_DEPTH(DEPTH), .DIV_W(16)) dut (
        .clk(clk), .rst(rst),
        .cfg_wr(cfg_wr), .cfg_div(cfg_div), .cfg_data_bit_num(cfg_data_bit_num),
        .cfg_stop_bit_num(cfg_stop_bit_num), .cfg_parity_en(cfg_parity_en),
        .cfg_parity_type(cfg_parity_type), .cfg_rts_thresh(cfg_rts_thresh),
        .cfg_busy(cfg_busy), .rx(rx), .rx_done(rx_done), .rx_data(rx_data),
        .parity_error(parity_error), .tick(tick), .data_bit_num(data_bit_num),
        .stop_bit_num(stop_bit_num), .parity_en(parity_en), .parity_type(parity_type),
        .rts_n(rts_n), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .rd_perr(rd_perr), .level(level), .overrun(overrun), .overrun_clr(overrun_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every host pop must return the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && rd_valid && rd_ready) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL fifo_pop: got %h expected no entry", {rd_perr, rd_data});
            end else begin
                logic [8:0] exp;
                exp = sb.pop_front();
                if ({rd_perr, rd_data} !== exp) begin
                    failures++;
                    $display("FAIL fifo_pop: got %h expected %h", {rd_perr, rd_data}, exp);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [15:0] d, input logic [1:0] dbn, input logic sbn,
                             input logic pen, input logic pt, input logic [3:0] thr);
        cfg_div = d;
        cfg_data_bit_num = dbn;
        cfg_stop_bit_num = sbn;
        cfg_parity_en = pen;
        cfg_parity_type = pt;
        cfg_rts_thresh = thr;
        cfg_wr = 1'b1;
        step();
        cfg_wr = 1'b0;
    endtask

    task automatic push(input logic [7:0] d, input logic p);
        bit pop_now;
        bit acc;
        pop_now = rd_ready && (exp_level > 0);
        acc = (exp_level < DEPTH) || pop_now;
        if (acc) sb.push_back({p, d});
        exp_level = exp_level + int'(acc) - int'(pop_now);
        rx_done = 1'b1;
        rx_data = d;
        parity_error = p;
        step();
        rx_done = 1'b0;
        rx_data = '0;
        parity_error = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        rd_ready = 1'b1;
        while (rd_valid && n < 20) begin
            step();
            n++;
        end
        rd_ready = 1'b0;
        exp_level = 0;
        check("drain_bound", n < 20, 1);
        check("drain_level", level, 0);
        check("drain_rd_valid", rd_valid, 0);
        check("drain_rd_data", rd_data, 0);
    endtask

    task automatic first_tick(input string name, input int exp);
        int first;
        first = 0;
        for (int i = 1; i <= 60; i++) begin
            step();
            if (tick) begin
                first = i;
                break;
            end
        end
        check(name, first, exp);
    endtask

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        repeat (3) step();
        check("rst_tick", tick, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_rd_perr", rd_perr, 0);
        check("rst_level", level, 0);
        check("rst_overrun", overrun, 0);
        check("rst_cfg_busy", cfg_busy, 0);
        check("rst_dbn", data_bit_num, 2'b11);
        check("rst_sbn", stop_bit_num, 0);
        check("rst_pen", parity_en, 0);
        check("rst_ptype", parity_type, 0);
        check("rst_rts_n", rts_n, 0);
        rst = 1'b0;

        // Default divisor 27: tick on cycles 27, 54, 81 after release.
        for (int i = 1; i <= 81; i++) begin
            step();
            check("tick_div27", tick, (i % 27 == 0) ? 1 : 0);
        end

        // div=0 behaves as div=1; also exercise the pass-through fields.
        cfg_write(16'd0, 2'b11, 1'b1, 1'b1, 1'b1, 4'd6);
        check("div0_busy_set", cfg_busy, 1);
        step();
        check("div0_busy_clr", cfg_busy, 0);
        check("div0_tick_apply", tick, 0);
        check("div0_sbn", stop_bit_num, 1);
        check("div0_pen", parity_en, 1);
        check("div0_ptype", parity_type, 1);
        for (int i = 0; i < 5; i++) begin
            step();
            check("div0_tick", tick, 1);
        end

        // Deferred apply across a frame.
        rx = 1'b0;
        step();
        rx = 1'b1;
        cfg_write(16'd27, 2'b00, 1'b0, 1'b0, 1'b0, 4'd6);
        check("defer_busy", cfg_busy, 1);
        check("defer_dbn_hold", data_bit_num, 2'b11);
        repeat (3) step();
        check("defer_busy_frame", cfg_busy, 1);
        check("defer_dbn_frame", data_bit_num, 2'b11);
        push(8'hC3, 1'b0);
        step();
        check("defer_dbn_applied", data_bit_num, 2'b00);
        check("defer_busy_clr", cfg_busy, 0);
        check("defer_sbn", stop_bit_num, 0);
        drain();

        // Two writes in one frame: only the last divisor is applied.
        rx = 1'b0;
        step();
        rx = 1'b1;
        cfg_write(16'd10, 2'b11, 1'b0, 1'b0, 1'b0, 4'd6);
        cfg_write(16'd20, 2'b11, 1'b0, 1'b0, 1'b0, 4'd6);
        check("b2b_busy", cfg_busy, 1);
        push(8'h3C, 1'b1);
        step();
        check("b2b_busy_clr", cfg_busy, 0);
        check("b2b_dbn", data_bit_num, 2'b11);
        first_tick("b2b_first_tick", 20);
        drain();

        // FIFO fill with threshold 6.
        push(8'h55, 1'b1);
        check("fill_rd_valid", rd_valid, 1);
        check("fill_rd_data", rd_data, 8'h55);
        check("fill_rd_perr", rd_perr, 1);
        check("fill_level1", level, 1);
        check("fill_rts1", rts_n, 0);
        for (int k = 1; k <= 6; k++) begin
            logic [7:0] b;
            b = 8'(k);
            push(b, b[0]);
            check("fill_level", level, k + 1);
            check("fill_rts", rts_n, (k + 1 >= 6) ? 1 : 0);
        end
        push(8'hA1, 1'b0);
        push(8'hA2, 1'b1);
        push(8'hA3, 1'b0);
        check("full_level", level, 8);
        check("full_overrun", overrun, 1);
        check("full_head", rd_data, 8'h55);

        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        check("ovr_clear", overrun, 0);

        // Push and pop together at full.
        rd_ready = 1'b1;
        push(8'hB0, 1'b0);
        rd_ready = 1'b0;
        check("pushpop_level", level, 8);
        check("pushpop_overrun", overrun, 0);
        check("pushpop_head", rd_data, 8'h01);

        // Clear loses to a simultaneous drop.
        overrun_clr = 1'b1;
        push(8'hEE, 1'b1);
        overrun_clr = 1'b0;
        check("ovr_set_wins", overrun, 1);
        check("ovr_level", level, 8);
        drain();

        // Reset with data buffered and a configuration pending.
        for (int k = 0; k < 5; k++) push(8'h11 + 8'(k), 1'b0);
        rx = 1'b0;
        step();
        rx = 1'b1;
        cfg_write(16'd5, 2'b01, 1'b0, 1'b0, 1'b0, 4'd3);
        check("pre_rst_busy", cfg_busy, 1);
        check("pre_rst_level", level, 5);
        rst = 1'b1;
        sb.delete();
        exp_level = 0;
        step();
        check("mid_rst_level", level, 0);
        check("mid_rst_rd_valid", rd_valid, 0);
        check("mid_rst_busy", cfg_busy, 0);
        check("mid_rst_dbn", data_bit_num, 2'b11);
        check("mid_rst_overrun", overrun, 0);
        check("mid_rst_rts_n", rts_n, 0);
        check("mid_rst_tick", tick, 0);
        rst = 1'b0;
        first_tick("post_rst_first_tick", 27);
        check("post_rst_dbn", data_bit_num, 2'b11);
        for (int k = 0; k < 5; k++) push(8'h80 + 8'(k), 1'b1);
        check("post_rst_rts5", rts_n, 0);
        push(8'h85, 1'b0);
        check("post_rst_rts6", rts_n, 1);
        drain();
        check("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Controller that sequences and configures the `uart_rx` receiver core.
- Generates the 16x oversampling `tick` from a programmable divisor.
- Holds the active frame configuration and applies host updates only between frames.
- Buffers received bytes with their parity status in a FIFO.
- Drives receiver flow control (`rts_n`) from FIFO occupancy.
- Sits between the host register interface and `uart_rx`.

## Interface
- `FIFO_DEPTH`, 8: receive FIFO entries; must be a power of two, ≥ 2.
- `DIV_W`, 16: width of the baud divisor.
- `LVL_W`, $clog2(FIFO_DEPTH)+1: width of the level and threshold fields (derived).

- `clk`  in  1  single clock domain for all logic.
- `rst`  in  1  synchronous, active-high reset.
- `cfg_wr`  in  1  one-cycle strobe; captures all `cfg_*` inputs into the shadow set.
- `cfg_div`  in  DIV_W  tick divisor.
- `cfg_data_bit_num`  in  2  00=5, 01=6, 10=7, 11=8 data bits.
- `cfg_stop_bit_num`  in  1  0=1 stop bit, 1=2 stop bits.
- `cfg_parity_en`  in  1  parity enable.
- `cfg_parity_type`  in  1  parity type, passed through unchanged.
- `cfg_rts_thresh`  in  LVL_W  FIFO level at which `rts_n` deasserts.
- `cfg_busy`  out  1  shadow configuration pending, not yet applied.
- `rx`  in  1  serial line, already synchronized; used only for frame-start detection.
- `rx_done`  in  1  one-cycle strobe from `uart_rx`; byte complete.
- `rx_data`  in  8  received byte; valid with `rx_done`.
- `parity_error`  in  1  parity status; valid with `rx_done`.
- `tick`  out  1  oversampling strobe to `uart_rx`.
- `data_bit_num`  out  2  active configuration to `uart_rx`.
- `stop_bit_num`  out  1  active configuration to `uart_rx`.
- `parity_en`  out  1  active configuration to `uart_rx`.
- `parity_type`  out  1  active configuration to `uart_rx`.
- `rts_n`  out  1  to `uart_rx` `rts_n`; low means space is available.
- `rd_valid`  out  1  FIFO non-empty.
- `rd_ready`  in  1  host pop.
- `rd_data`  out  8  head byte.
- `rd_perr`  out  1  parity error flag of the head byte.
- `level`  out  LVL_W  FIFO occupancy, 0..FIFO_DEPTH.
- `overrun`  out  1  sticky flag; a byte was dropped because the FIFO was full.
- `overrun_clr`  in  1  clears `overrun`.

## Operation
- **Tick generator**
  - Counter `tcnt` counts 0..div-1.
  - `tick`=1 for one cycle when `tcnt`==div-1, then `tcnt` wraps to 0.
  - div=0 behaves as div=1: `tick` is high every cycle.
  - Applying a configuration resets `tcnt` to 0.
- **Frame tracking**, flag `frame_active`:
  - Set when `frame_active`=0 and `rx`=0.
  - Cleared on `rx_done`; clear has priority over set in the same cycle.
- **Configuration FSM**, states IDLE_CFG and PENDING:
  - IDLE_CFG -> PENDING on `cfg_wr`; the shadow set is loaded.
  - PENDING with `frame_active`=0: the shadow set is copied to the active set, `tcnt` is cleared, and the FSM returns to IDLE_CFG.
  - `cfg_wr` while PENDING overwrites the shadow set and stays PENDING.
  - If `cfg_wr` coincides with an apply, the old shadow is applied and the FSM stays PENDING holding the new shadow.
  - `cfg_busy` = (state==PENDING).
- **FIFO** entries are {`parity_error`, `rx_data`}.
  - Push on `rx_done`.
  - Pop when `rd_valid` && `rd_ready`.
  - Push while full with no pop: the byte is dropped and `overrun` is set.
  - Push and pop while full: both succeed, `level` is unchanged, no overrun.
  - Push and pop while empty: push only, since `rd_valid`=0.
  - Pointers are log2(FIFO_DEPTH) bits and wrap naturally.
- **Outputs**
  - `rd_data`/`rd_perr` are read combinationally from the head entry; both are 0 when empty.
  - `rts_n` = (`level` >= active threshold), combinational from the `level` register. Threshold 0 keeps `rts_n`=1 permanently.
  - `overrun`: set has priority over `overrun_clr`.

## Timing
- **Reset values:**
  - `tick`=0, `tcnt`=0.
  - `rd_valid`=0, `rd_data`=0, `rd_perr`=0, `level`=0.
  - `overrun`=0, `cfg_busy`=0, `frame_active`=0.
  - Active set: div=27, `data_bit_num`=11, `stop_bit_num`=0, `parity_en`=0, `parity_type`=0, threshold=FIFO_DEPTH-2.
  - `rts_n`=0.
- Reset asserted mid-frame or mid-pending takes effect at the next edge and discards FIFO contents and the shadow set.
- `cfg_wr` at cycle N:
  - `cfg_busy`=1 at N+1.
  - If idle at N+1, the active outputs change and `cfg_busy`=0 at N+2.
- `rx_done` at cycle N:
  - Entry visible with `rd_valid`=1 and `level` incremented at N+1.
  - `rts_n` updates at N+1.
- Pop at cycle N: the next entry appears at N+1.
- After a configuration apply, the first `tick` occurs div cycles later.

## Test plan
- **Tick generator:** reset, div=27 -> first `tick` at cycle 27 after reset release, then every 27 cycles. Write div=0 -> `tick` high every cycle after apply.
- **Deferred apply:** drive `rx` low (frame start), `cfg_wr` with `data_bit_num`=00 -> `cfg_busy`=1 and outputs stay 11 until `rx_done`; the cycle after `rx_done`, outputs become 00 and `cfg_busy`=0.
- **Back-to-back writes:** two `cfg_wr` during one frame (div=10, then div=20) -> only div=20 is applied after `rx_done`.
- **FIFO fill, DEPTH=8, threshold=6:**
  - Push 0x55 with `parity_error`=1 -> `rd_data`=0x55, `rd_perr`=1.
  - Push 6 bytes -> `rts_n`=1 once `level`=6.
  - Push 3 more -> `level`=8, `overrun`=1, 9th byte absent.
  - Drain -> bytes returned in order.
- **Full-boundary push/pop:** at `level`=8, push and pop in the same cycle -> `level` stays 8, `overrun` stays 0. `overrun_clr` together with a dropped push -> `overrun` remains 1.
- **Reset mid-operation:** `rst` asserted with `level`=5 and PENDING -> next cycle `level`=0, `rd_valid`=0, `cfg_busy`=0, defaults restored.
